// File: rtl/rs_scheduler.sv
// Allocation/dispatch controller for one FU's reservation stations:
// lowest-free allocation on issue, oldest-ready dispatch with a sticky handshake lock.
module rs_scheduler #(
    parameter int N_RS = 3,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            issue_valid,
    output logic            issue_ready,
    output logic            alloc_en,
    output logic [ID_W-1:0] alloc_id,
    input  logic [N_RS-1:0] entry_ready,
    output logic            fu_valid,
    output logic [ID_W-1:0] fu_id,
    input  logic            fu_ready,
    output logic [N_RS-1:0] busy_vec,
    output logic [ID_W-1:0] free_count
);

    function automatic logic [ID_W-1:0] popcount(input logic [N_RS-1:0] v);
        logic [ID_W-1:0] cnt;
        cnt = {ID_W{1'b0}};
        for (int i = 0; i < N_RS; i++) begin
            cnt = cnt + ID_W'(v[i]);
        end
        return cnt;
    endfunction

    logic [N_RS-1:0] busy_r;
    logic [N_RS-1:0] older_r [N_RS];
    logic            lock_r;
    logic [ID_W-1:0] locked_id_r;

    logic [N_RS-1:0] busy_n;
    logic [N_RS-1:0] older_n [N_RS];
    logic            lock_n;
    logic [ID_W-1:0] locked_id_n;

    logic [N_RS-1:0] elig_s;
    logic [N_RS-1:0] blocked_s;
    logic [ID_W-1:0] sel_s;
    logic            fire_s;

    // Allocation side: lowest-index free entry from the registered busy bits
    always_comb begin
        alloc_id = {ID_W{1'b0}};
        for (int i = N_RS - 1; i >= 0; i--) begin
            alloc_id = busy_r[i] ? alloc_id : ID_W'(i);
        end
    end

    assign issue_ready = ~&busy_r;
    assign alloc_en    = issue_valid & issue_ready & ~flush;
    assign busy_vec    = busy_r;
    assign free_count  = ID_W'(N_RS) - popcount(busy_r);
    assign elig_s      = busy_r & entry_ready;

    // An eligible entry is blocked when any other eligible entry is older
    always_comb begin
        blocked_s = {N_RS{1'b0}};
        for (int i = 0; i < N_RS; i++) begin
            for (int j = 0; j < N_RS; j++) begin
                blocked_s[i] = blocked_s[i] | (elig_s[j] & older_r[j][i]);
            end
        end
    end

    // Oldest-ready select; ages are unique so at most one entry is unblocked
    always_comb begin
        sel_s = {ID_W{1'b0}};
        for (int i = 0; i < N_RS; i++) begin
            sel_s = (elig_s[i] & ~blocked_s[i]) ? ID_W'(i) : sel_s;
        end
    end

    // Once offered, a dispatch stays on the same entry until the FU takes it
    always_comb begin
        if (lock_r) begin
            fu_valid = 1'b1;
            fu_id    = locked_id_r;
        end else begin
            fu_valid = |elig_s;
            fu_id    = sel_s;
        end
    end

    assign fire_s = fu_valid & fu_ready;

    // Next-state: allocation stamps the new entry youngest; a fire wipes its row/column
    always_comb begin
        busy_n      = busy_r;
        older_n     = older_r;
        lock_n      = lock_r;
        locked_id_n = locked_id_r;
        if (flush) begin
            busy_n = {N_RS{1'b0}};
            for (int i = 0; i < N_RS; i++) begin
                older_n[i] = {N_RS{1'b0}};
            end
            lock_n = 1'b0;
        end else begin
            for (int i = 0; i < N_RS; i++) begin
                if (alloc_en && (ID_W'(i) == alloc_id)) begin
                    busy_n[i] = 1'b1;
                    for (int j = 0; j < N_RS; j++) begin
                        older_n[j][i] = busy_r[j];
                        older_n[i][j] = 1'b0;
                    end
                end else begin
                    busy_n[i] = busy_n[i];
                end
            end
            if (fire_s) begin
                lock_n = 1'b0;
                for (int i = 0; i < N_RS; i++) begin
                    if (ID_W'(i) == fu_id) begin
                        busy_n[i] = 1'b0;
                        for (int j = 0; j < N_RS; j++) begin
                            older_n[i][j] = 1'b0;
                            older_n[j][i] = 1'b0;
                        end
                    end else begin
                        busy_n[i] = busy_n[i];
                    end
                end
            end else if (fu_valid) begin
                lock_n      = 1'b1;
                locked_id_n = fu_id;
            end else begin
                lock_n = lock_r;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= {N_RS{1'b0}};
            lock_r      <= 1'b0;
            locked_id_r <= {ID_W{1'b0}};
            for (int i = 0; i < N_RS; i++) begin
                older_r[i] <= {N_RS{1'b0}};
            end
        end else begin
            busy_r      <= busy_n;
            lock_r      <= lock_n;
            locked_id_r <= locked_id_n;
            for (int i = 0; i < N_RS; i++) begin
                older_r[i] <= older_n[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler: per-cycle comparison against a timestamp-based
// reference model, plus hand-computed literal expectations from the test plan.
module tb_rs_scheduler;
    localparam int N = 3;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         issue_valid;
    logic         issue_ready;
    logic         alloc_en;
    logic [W-1:0] alloc_id;
    logic [N-1:0] entry_ready;
    logic         fu_valid;
    logic [W-1:0] fu_id;
    logic         fu_ready;
    logic [N-1:0] busy_vec;
    logic [W-1:0] free_count;

    rs_scheduler #(.N_RS(N), .ID_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .alloc_en(alloc_en), .alloc_id(alloc_id),
        .entry_ready(entry_ready), .fu_valid(fu_valid), .fu_id(fu_id),
        .fu_ready(fu_ready), .busy_vec(busy_vec), .free_count(free_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: busy flags, allocation timestamps, lock state
    bit mbusy [N];
    int mstamp [N];
    int mclock = 0;
    bit mlock = 1'b0;
    int mlid = 0;

    // Values sampled during the last step, for literal checks
    logic         s_ready, s_aen, s_fv;
    logic [W-1:0] s_aid, s_fid, s_fc;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
        mlock = 1'b0;
        mlid = 0;
    endtask

    // One cycle: drive, compare against model, clock, advance model
    task automatic step(input bit iv, input logic [N-1:0] er, input bit fr, input bit fl);
        bit e_ready, e_aen, e_fv;
        int e_aid, e_fid, nfree, best;
        logic [N-1:0] e_busy;
        issue_valid = iv; entry_ready = er; fu_ready = fr; flush = fl;
        #2;
        nfree = 0; e_aid = -1; e_busy = '0;
        for (int i = 0; i < N; i++) begin
            e_busy[i] = mbusy[i];
            if (!mbusy[i]) begin
                nfree++;
                if (e_aid < 0) e_aid = i;
            end
        end
        e_ready = (nfree > 0);
        e_aen = iv && e_ready && !fl;
        if (mlock) begin
            e_fv = 1'b1; e_fid = mlid;
        end else begin
            e_fv = 1'b0; e_fid = 0; best = -1;
            for (int i = 0; i < N; i++) begin
                if (mbusy[i] && er[i] && (best < 0 || mstamp[i] < best)) begin
                    best = mstamp[i]; e_fid = i; e_fv = 1'b1;
                end
            end
        end
        s_ready = issue_ready; s_aen = alloc_en; s_aid = alloc_id;
        s_fv = fu_valid; s_fid = fu_id; s_fc = free_count;
        chk("issue_ready", 8'(issue_ready), 8'(e_ready));
        chk("alloc_en", 8'(alloc_en), 8'(e_aen));
        if (e_ready) chk("alloc_id", 8'(alloc_id), 8'(e_aid));
        chk("fu_valid", 8'(fu_valid), 8'(e_fv));
        if (e_fv) chk("fu_id", 8'(fu_id), 8'(e_fid));
        chk("busy_vec", 8'(busy_vec), 8'(e_busy));
        chk("free_count", 8'(free_count), 8'(nfree));
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (e_aen) begin
                mbusy[e_aid] = 1'b1; mstamp[e_aid] = mclock; mclock++;
            end
            if (e_fv && fr) begin
                mbusy[e_fid] = 1'b0; mlock = 1'b0;
            end else if (e_fv) begin
                mlock = 1'b1; mlid = e_fid;
            end
        end
        #1;
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b1; entry_ready = '0; fu_ready = 1'b0;
        #12;
        chk("rst_issue_ready", 8'(issue_ready), 8'd1);
        chk("rst_alloc_id", 8'(alloc_id), 8'd0);
        chk("rst_alloc_en", 8'(alloc_en), 8'd1);
        chk("rst_fu_valid", 8'(fu_valid), 8'd0);
        chk("rst_fu_id", 8'(fu_id), 8'd0);
        chk("rst_free_count", 8'(free_count), 8'd3);
        chk("rst_busy", 8'(busy_vec), 8'd0);
        issue_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill all three entries
        step(1, 3'b000, 0, 0); chk("fill_aid0", 8'(s_aid), 8'd0); chk("fill_busy1", 8'(busy_vec), 8'b001);
        step(1, 3'b000, 0, 0); chk("fill_aid1", 8'(s_aid), 8'd1); chk("fill_busy2", 8'(busy_vec), 8'b011);
        step(1, 3'b000, 0, 0); chk("fill_aid2", 8'(s_aid), 8'd2); chk("fill_busy3", 8'(busy_vec), 8'b111);
        step(1, 3'b000, 0, 0);
        chk("full_ready", 8'(s_ready), 8'd0); chk("full_aen", 8'(s_aen), 8'd0);
        chk("full_fc", 8'(s_fc), 8'd0); chk("full_busy", 8'(busy_vec), 8'b111);

        // Oldest-ready among entries 1,2
        step(0, 3'b110, 1, 0); chk("d1_fid", 8'(s_fid), 8'd1); chk("d1_busy", 8'(busy_vec), 8'b101);
        step(0, 3'b110, 1, 0); chk("d2_fid", 8'(s_fid), 8'd2); chk("d2_busy", 8'(busy_vec), 8'b001);
        step(0, 3'b110, 1, 0); chk("d3_fv", 8'(s_fv), 8'd0);

        // Re-allocated entry 0 becomes youngest
        step(1, 3'b000, 0, 0); step(1, 3'b000, 0, 0);
        step(0, 3'b001, 1, 0); chk("free0_fid", 8'(s_fid), 8'd0); chk("free0_busy", 8'(busy_vec), 8'b110);
        step(1, 3'b000, 0, 0); chk("realloc_aid", 8'(s_aid), 8'd0);
        step(0, 3'b111, 1, 0); chk("ord_a", 8'(s_fid), 8'd1);
        step(0, 3'b111, 1, 0); chk("ord_b", 8'(s_fid), 8'd2);
        step(0, 3'b111, 1, 0); chk("ord_c", 8'(s_fid), 8'd0);
        chk("ord_empty", 8'(busy_vec), 8'b000);

        // Lock holds entry 2 while older entry 1 becomes ready
        step(1, 3'b000, 0, 0); step(1, 3'b000, 0, 0); step(1, 3'b000, 0, 0);
        step(0, 3'b100, 0, 0); chk("lk_fid_a", 8'(s_fid), 8'd2);
        step(0, 3'b110, 0, 0); chk("lk_fid_b", 8'(s_fid), 8'd2);
        step(0, 3'b110, 1, 0); chk("lk_fire", 8'(s_fid), 8'd2);
        step(0, 3'b110, 1, 0); chk("lk_next", 8'(s_fid), 8'd1);
        step(0, 3'b001, 1, 0); chk("lk_last", 8'(s_fid), 8'd0);

        // Simultaneous fire and allocate, then flush over a pending fire
        step(1, 3'b000, 0, 0); step(1, 3'b000, 0, 0);
        step(1, 3'b001, 1, 0);
        chk("sim_aid", 8'(s_aid), 8'd2); chk("sim_fid", 8'(s_fid), 8'd0);
        chk("sim_busy", 8'(busy_vec), 8'b110);
        step(1, 3'b000, 0, 0); chk("sim_busy_full", 8'(busy_vec), 8'b111);
        step(1, 3'b010, 1, 1);
        chk("fl_aen", 8'(s_aen), 8'd0); chk("fl_fv", 8'(s_fv), 8'd1);
        chk("fl_busy", 8'(busy_vec), 8'b000);
        step(0, 3'b000, 0, 0); chk("fl_unlocked", 8'(s_fv), 8'd0);

        // Async reset while locked
        step(1, 3'b000, 0, 0);
        step(0, 3'b001, 0, 0); chk("pre_lock", 8'(s_fv), 8'd1);
        issue_valid = 1'b0; entry_ready = '0; fu_ready = 1'b0; flush = 1'b0;
        #2; chk("still_locked", 8'(fu_valid), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_fv", 8'(fu_valid), 8'd0);
        chk("arst_busy", 8'(busy_vec), 8'd0);
        chk("arst_ready", 8'(issue_ready), 8'd1);
        model_clear();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 3'b111, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
